muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV64 M-extension, which the single-cycle core hands multiply/divide instructions to instead of evaluating them in one combinational ALU pass. It captures operands on `start`, runs an iterative radix-2 shift-add multiplier or restoring divider, and applies sign correction. It holds the core's PC and register write through `stall` until the one-cycle `done` window. On `done` the core commits `result` and advances.

---
 rtl/muldiv_seq_if.sv | 14 +
 rtl/muldiv_seq.sv | 111 +++++++++++
 tb/tb_muldiv_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: issue/commit handshake between the core and the M-extension sequencer.
interface muldiv_seq_if #(parameter int XLEN = 64);
    logic            start;
    logic [2:0]      funct3;
    logic            op32;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, funct3, op32, a, b, input busy, stall, done, result);
    modport slave (input start, funct3, op32, a, b, output busy, stall, done, result);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 multiply / restoring divide sequencer for RV64 M-extension.
module muldiv_seq #(parameter int XLEN = 64) (
    input logic clk,
    input logic reset,
    muldiv_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
    localparam int CW = $clog2(XLEN + 1);

    state_t            state, state_nx;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] acc, mul_nx, div_nx, prod, prod_s;
    logic [XLEN-1:0]   opr, result_q;
    logic [2:0]        f_q, f_in;
    logic              op32_q, neg_q, a_neg_q;
    logic              a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, special;
    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val, sp_val, quo_s, rem_s, field;
    logic [XLEN:0]     sum, sh, diff;

    function automatic logic [XLEN-1:0] fit(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Undefined W-variants of MULH* collapse to MULW here.
    always_comb begin
        f_in    = (bus.op32 && !bus.funct3[2]) ? 3'b000 : bus.funct3;
        a_sgn   = f_in[2] ? !f_in[0] : (f_in[1:0] != 2'b11);
        b_sgn   = f_in[2] ? !f_in[0] : !f_in[1];
        a_ext   = bus.op32 ? {{(XLEN-32){a_sgn & bus.a[31]}}, bus.a[31:0]} : bus.a;
        b_ext   = bus.op32 ? {{(XLEN-32){b_sgn & bus.b[31]}}, bus.b[31:0]} : bus.b;
        a_neg   = a_sgn & a_ext[XLEN-1];
        b_neg   = b_sgn & b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        min_val = bus.op32 ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        b_zero  = b_ext == '0;
        ovf     = f_in[2] && !f_in[0] && (&b_ext) && a_ext == min_val;
        special = f_in[2] && (b_zero || ovf);
        sp_val  = b_zero ? (f_in[1] ? a_ext : '1) : (f_in[1] ? '0 : a_ext);
    end

    always_comb begin
        sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opr};
        mul_nx = acc[0] ? {sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        sh     = acc[2*XLEN-1:XLEN-1];
        diff   = sh - {1'b0, opr};
        div_nx = diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        // A 32-iteration product sits XLEN-32 bits too high in the accumulator.
        prod   = op32_q ? acc >> (XLEN - 32) : acc;
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s  = a_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        field  = !f_q[2] ? (f_q[1:0] == 2'b00 ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN])
                         : (f_q[1] ? rem_s : quo_s);
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = !bus.start ? IDLE : special ? DONE : f_in[2] ? DIV : MUL;
            MUL,
            DIV:     state_nx = count == CW'(1) ? FIX : state;
            FIX:     state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        bus.busy   = state == MUL || state == DIV || state == FIX;
        bus.done   = state == DONE;
        bus.stall  = (state == IDLE && bus.start) || bus.busy;
        bus.result = result_q;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            count    <= '0;
            acc      <= '0;
            opr      <= '0;
            f_q      <= '0;
            op32_q   <= 1'b0;
            neg_q    <= 1'b0;
            a_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    count   <= bus.op32 ? CW'(32) : CW'(XLEN);
                    f_q     <= f_in;
                    op32_q  <= bus.op32;
                    neg_q   <= a_neg ^ b_neg;
                    a_neg_q <= a_neg;
                    opr     <= f_in[2] ? b_mag : a_mag;
                    acc     <= f_in[2] ? {{XLEN{1'b0}}, bus.op32 ? a_mag << (XLEN - 32) : a_mag}
                                       : {{XLEN{1'b0}}, b_mag};
                    if (special) result_q <= fit(sp_val, bus.op32);
                end
                MUL: begin
                    acc   <= mul_nx;
                    count <= count - 1'b1;
                end
                DIV: begin
                    acc   <= div_nx;
                    count <= count - 1'b1;
                end
                FIX:     result_q <= fit(field, op32_q);
                default: ;
            endcase
        end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed and randomized checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [63:0] pool [8] = '{64'd0, 64'd1, '1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000,
                              64'h0000_0000_FFFF_FFFF, 64'd7, 64'h7FFF_FFFF_FFFF_FFFF};

    muldiv_seq_if #(.XLEN(64)) bus ();
    muldiv_seq #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] ref_model(input logic [2:0] f, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb, ua, ub;
        logic [127:0] p;
        logic signed [31:0] a32, b32;
        logic [31:0] r32;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        ua = {64'd0, a};
        ub = {64'd0, b};
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (!f[2]) r32 = a[31:0] * b[31:0];
            else if (b32 == 0) r32 = f[1] ? a[31:0] : '1;
            else if (!f[0] && a32 == 32'sh8000_0000 && b32 == -1) r32 = f[1] ? 32'd0 : a[31:0];
            else case (f[1:0])
                2'b00:   r32 = a32 / b32;
                2'b01:   r32 = a[31:0] / b[31:0];
                2'b10:   r32 = a32 % b32;
                default: r32 = a[31:0] % b[31:0];
            endcase
            return {{32{r32[31]}}, r32};
        end
        if (!f[2]) begin
            case (f[1:0])
                2'b01:   p = sa * sb;
                2'b10:   p = sa * ub;
                default: p = ua * ub;
            endcase
            r = f[1:0] == 2'b00 ? p[63:0] : p[127:64];
        end
        else if (b == 0) r = f[1] ? a : '1;
        else if (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1) r = f[1] ? 64'd0 : a;
        else case (f[1:0])
            2'b00:   r = $signed(a) / $signed(b);
            2'b01:   r = a / b;
            2'b10:   r = $signed(a) % $signed(b);
            default: r = a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
        if (!f[2]) return 1'b0;
        if (w) return b[31:0] == 0 || (!f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
        return b == 0 || (!f[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 back in IDLE.
    task automatic issue(input string tag, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b);
        logic [63:0] exp;
        int lat, exp_lat;
        bit sp, stall_ok, busy_ok;
        exp = ref_model(f, w, a, b);
        sp = is_special(f, w, a, b);
        exp_lat = sp ? 1 : (w ? 34 : 66);
        bus.start = 1'b1;
        bus.funct3 = f;
        bus.op32 = w;
        bus.a = a;
        bus.b = b;
        #1 check({tag, "/stall_issue"}, 64'(bus.stall), 64'd1);
        lat = 0;
        stall_ok = 1'b1;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            bus.a = {$urandom, $urandom};
            bus.b = {$urandom, $urandom};
            bus.funct3 = 3'($urandom);
            bus.op32 = 1'($urandom);
            if (!bus.done) begin
                stall_ok = stall_ok && bus.stall;
                busy_ok = busy_ok && (bus.busy == !sp);
            end
        end while (!bus.done && lat < 100);
        check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "/result"}, bus.result, exp);
        check({tag, "/stall_wait"}, 64'(stall_ok), 64'd1);
        check({tag, "/busy_wait"}, 64'(busy_ok), 64'd1);
        bus.start = 1'b1;
        #1 check({tag, "/stall_done"}, 64'(bus.stall), 64'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "/idle_after"}, {62'd0, bus.done, bus.busy}, 64'd0);
        check({tag, "/hold"}, bus.result, exp);
    endtask

    initial begin
        int t1, t2, npulse;
        bus.start = 1'b1;
        bus.funct3 = 3'd0;
        bus.op32 = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(posedge clk);
        #1 check("rst/stall_start1", 64'(bus.stall), 64'd1);
        bus.start = 1'b0;
        #1 check("rst/stall_start0", 64'(bus.stall), 64'd0);
        check("rst/busy_done", {62'd0, bus.busy, bus.done}, 64'd0);
        check("rst/result", bus.result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        issue("mul_7x-3", 3'b000, 1'b0, 64'd7, -64'd3);
        check("mul_7x-3/const", bus.result, 64'hFFFF_FFFF_FFFF_FFEB);
        issue("mulhu_ones", 3'b011, 1'b0, '1, '1);
        check("mulhu_ones/const", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
        issue("mulh_m1", 3'b001, 1'b0, '1, '1);
        check("mulh_m1/const", bus.result, 64'd0);
        issue("div_-7/2", 3'b100, 1'b0, -64'd7, 64'd2);
        check("div_-7/2/const", bus.result, -64'd3);
        issue("rem_-7/2", 3'b110, 1'b0, -64'd7, 64'd2);
        check("rem_-7/2/const", bus.result, '1);
        issue("divuw", 3'b101, 1'b1, 64'h1_0000_0010, 64'd3);
        check("divuw/const", bus.result, 64'd5);
        issue("div_by0", 3'b100, 1'b0, 64'd99, 64'd0);
        check("div_by0/const", bus.result, '1);
        issue("remu_by0", 3'b111, 1'b0, 64'h1234, 64'd0);
        check("remu_by0/const", bus.result, 64'h1234);
        issue("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1);
        check("div_ovf/const", bus.result, 64'h8000_0000_0000_0000);

        // start held high across two MULW issues
        bus.start = 1'b1;
        bus.funct3 = 3'b000;
        bus.op32 = 1'b1;
        bus.a = 64'd3;
        bus.b = 64'd5;
        npulse = 0;
        t1 = -1;
        t2 = -1;
        for (int c = 1; c <= 150; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                npulse++;
                if (t1 < 0) t1 = c;
                else t2 = c;
            end
            if (t1 > 0 && c == t1 + 1)
                check("b2b/idle_gap", {61'd0, bus.busy, bus.stall, bus.done}, 64'b010);
            if (t1 > 0 && c == t1 + 2) begin
                check("b2b/reissue", 64'(bus.busy), 64'd1);
                bus.start = 1'b0;
            end
        end
        check("b2b/pulses", 64'(npulse), 64'd2);
        check("b2b/first_done", 64'(t1), 64'd34);
        check("b2b/second_done", 64'(t2), 64'd69);
        check("b2b/result", bus.result, 64'd15);

        // reset in the middle of a 64-bit multiply
        bus.start = 1'b1;
        bus.funct3 = 3'b000;
        bus.op32 = 1'b0;
        bus.a = 64'd7;
        bus.b = 64'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #1 check("abort/busy_before", 64'(bus.busy), 64'd1);
        #2 reset = 1'b0;
        #1 check("abort/outputs", {61'd0, bus.busy, bus.done, bus.stall}, 64'd0);
        check("abort/result", bus.result, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        npulse = 0;
        repeat (80) begin
            @(posedge clk);
            #1 if (bus.done) npulse++;
        end
        check("abort/no_done", 64'(npulse), 64'd0);
        issue("mul_3x4", 3'b000, 1'b0, 64'd3, 64'd4);
        check("mul_3x4/const", bus.result, 64'd12);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : {$urandom, $urandom};
            rb = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 7)] : {$urandom, $urandom};
            issue($sformatf("rnd%0d", i), 3'($urandom), 1'($urandom), ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
